// File: rtl/per2axi_pkg.sv
// Shared types and AXI constants for the peripheral-to-AXI bridge.
package per2axi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        ATOP_RESP,
        RD_REQ,
        RD_RESP,
        RESP
    } state_e;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Atomic loads, swaps and compares return data on R as well as a B response.
    function automatic logic atop_has_rdata(input logic [5:0] atop);
        return atop[5];
    endfunction

endpackage

// File: rtl/per2axi_bridge.sv
// Single-outstanding peripheral request -> single-beat AXI4 master; 3 cycles grant-to-response when AXI is ready.
// Backpressure: gnt only in IDLE; AXI valids hold until ready; B/R waited on indefinitely.
module per2axi_bridge
    import per2axi_pkg::*;
#(
    parameter int unsigned PER_ADDR_WIDTH = 32,
    parameter int unsigned PER_ID_WIDTH   = 5,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 6,
    parameter int unsigned AXI_USER_WIDTH = 6
) (
    input  logic                        clk_i,
    input  logic                        rst_i,

    input  logic                        per_slave_req_i,
    input  logic [PER_ADDR_WIDTH-1:0]   per_slave_add_i,
    input  logic                        per_slave_we_ni,
    input  logic [31:0]                 per_slave_wdata_i,
    input  logic [3:0]                  per_slave_be_i,
    input  logic [5:0]                  per_slave_atop_i,
    input  logic [PER_ID_WIDTH-1:0]     per_slave_id_i,
    output logic                        per_slave_gnt_o,
    output logic                        per_slave_r_valid_o,
    output logic                        per_slave_r_opc_o,
    output logic [31:0]                 per_slave_r_rdata_o,
    output logic [PER_ID_WIDTH-1:0]     per_slave_r_id_o,

    output logic                        axi_aw_valid_o,
    output logic [PER_ADDR_WIDTH-1:0]   axi_aw_addr_o,
    output logic [2:0]                  axi_aw_prot_o,
    output logic [3:0]                  axi_aw_region_o,
    output logic [7:0]                  axi_aw_len_o,
    output logic [2:0]                  axi_aw_size_o,
    output logic [1:0]                  axi_aw_burst_o,
    output logic                        axi_aw_lock_o,
    output logic [3:0]                  axi_aw_cache_o,
    output logic [3:0]                  axi_aw_qos_o,
    output logic [5:0]                  axi_aw_atop_o,
    output logic [AXI_ID_WIDTH-1:0]     axi_aw_id_o,
    output logic [AXI_USER_WIDTH-1:0]   axi_aw_user_o,
    input  logic                        axi_aw_ready_i,

    output logic                        axi_w_valid_o,
    output logic [AXI_DATA_WIDTH-1:0]   axi_w_data_o,
    output logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb_o,
    output logic                        axi_w_last_o,
    output logic [AXI_USER_WIDTH-1:0]   axi_w_user_o,
    input  logic                        axi_w_ready_i,

    input  logic                        axi_b_valid_i,
    input  logic [1:0]                  axi_b_resp_i,
    input  logic [AXI_ID_WIDTH-1:0]     axi_b_id_i,
    input  logic [AXI_USER_WIDTH-1:0]   axi_b_user_i,
    output logic                        axi_b_ready_o,

    output logic                        axi_ar_valid_o,
    output logic [PER_ADDR_WIDTH-1:0]   axi_ar_addr_o,
    output logic [2:0]                  axi_ar_prot_o,
    output logic [3:0]                  axi_ar_region_o,
    output logic [7:0]                  axi_ar_len_o,
    output logic [2:0]                  axi_ar_size_o,
    output logic [1:0]                  axi_ar_burst_o,
    output logic                        axi_ar_lock_o,
    output logic [3:0]                  axi_ar_cache_o,
    output logic [3:0]                  axi_ar_qos_o,
    output logic [AXI_ID_WIDTH-1:0]     axi_ar_id_o,
    output logic [AXI_USER_WIDTH-1:0]   axi_ar_user_o,
    input  logic                        axi_ar_ready_i,

    input  logic                        axi_r_valid_i,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_r_data_i,
    input  logic [1:0]                  axi_r_resp_i,
    input  logic                        axi_r_last_i,
    input  logic [AXI_ID_WIDTH-1:0]     axi_r_id_i,
    input  logic [AXI_USER_WIDTH-1:0]   axi_r_user_i,
    output logic                        axi_r_ready_o,

    output logic                        busy_o
);

    state_e                    state_q, state_d;
    logic [PER_ADDR_WIDTH-1:0] add_q, add_d;
    logic [31:0]               wdata_q, wdata_d;
    logic [3:0]                be_q, be_d;
    logic [5:0]                atop_q, atop_d;
    logic [PER_ID_WIDTH-1:0]   id_q, id_d;
    logic [31:0]               rdata_q, rdata_d;
    logic                      opc_q, opc_d;
    logic                      aw_pend_q, aw_pend_d;
    logic                      w_pend_q, w_pend_d;
    logic                      b_done_q, b_done_d;
    logic                      r_done_q, r_done_d;

    logic        aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic [31:0] r_lane;

    // Single outstanding transaction, so response IDs and r_last carry no information.
    logic unused_axi_inputs;
    assign unused_axi_inputs = ^{axi_b_id_i, axi_b_user_i, axi_r_last_i, axi_r_id_i, axi_r_user_i};

    assign per_slave_gnt_o = per_slave_req_i && (state_q == IDLE);

    assign axi_aw_valid_o = (state_q == WR_REQ) && aw_pend_q;
    assign axi_w_valid_o  = (state_q == WR_REQ) && w_pend_q;
    assign axi_ar_valid_o = (state_q == RD_REQ);
    assign axi_b_ready_o  = (state_q == WR_RESP) || ((state_q == ATOP_RESP) && !b_done_q);
    assign axi_r_ready_o  = (state_q == RD_RESP) || ((state_q == ATOP_RESP) && !r_done_q);
    assign busy_o         = (state_q != IDLE);

    assign aw_hs = axi_aw_valid_o && axi_aw_ready_i;
    assign w_hs  = axi_w_valid_o  && axi_w_ready_i;
    assign ar_hs = axi_ar_valid_o && axi_ar_ready_i;
    assign b_hs  = axi_b_valid_i  && axi_b_ready_o;
    assign r_hs  = axi_r_valid_i  && axi_r_ready_o;

    assign r_lane = add_q[2] ? axi_r_data_i[63:32] : axi_r_data_i[31:0];

    assign per_slave_r_valid_o = (state_q == RESP);
    assign per_slave_r_opc_o   = (state_q == RESP) && opc_q;
    assign per_slave_r_rdata_o = (state_q == RESP) ? rdata_q : '0;
    assign per_slave_r_id_o    = (state_q == RESP) ? id_q : '0;

    assign axi_aw_addr_o   = add_q;
    assign axi_aw_prot_o   = '0;
    assign axi_aw_region_o = '0;
    assign axi_aw_len_o    = '0;
    assign axi_aw_size_o   = AXI_SIZE_4B;
    assign axi_aw_burst_o  = AXI_BURST_INCR;
    assign axi_aw_lock_o   = 1'b0;
    assign axi_aw_cache_o  = '0;
    assign axi_aw_qos_o    = '0;
    assign axi_aw_atop_o   = atop_q;
    assign axi_aw_id_o     = '0;
    assign axi_aw_user_o   = '0;

    assign axi_w_data_o = {wdata_q, wdata_q};
    assign axi_w_strb_o = add_q[2] ? {be_q, 4'h0} : {4'h0, be_q};
    assign axi_w_last_o = 1'b1;
    assign axi_w_user_o = '0;

    assign axi_ar_addr_o   = add_q;
    assign axi_ar_prot_o   = '0;
    assign axi_ar_region_o = '0;
    assign axi_ar_len_o    = '0;
    assign axi_ar_size_o   = AXI_SIZE_4B;
    assign axi_ar_burst_o  = AXI_BURST_INCR;
    assign axi_ar_lock_o   = 1'b0;
    assign axi_ar_cache_o  = '0;
    assign axi_ar_qos_o    = '0;
    assign axi_ar_id_o     = '0;
    assign axi_ar_user_o   = '0;

    always_comb begin
        state_d   = state_q;
        add_d     = add_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        atop_d    = atop_q;
        id_d      = id_q;
        rdata_d   = rdata_q;
        opc_d     = opc_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        b_done_d  = b_done_q;
        r_done_d  = r_done_q;

        case (state_q)
            IDLE: begin
                if (per_slave_gnt_o) begin
                    add_d    = per_slave_add_i;
                    wdata_d  = per_slave_wdata_i;
                    be_d     = per_slave_be_i;
                    atop_d   = per_slave_we_ni ? 6'h0 : per_slave_atop_i;
                    id_d     = per_slave_id_i;
                    rdata_d  = '0;
                    opc_d    = 1'b0;
                    b_done_d = 1'b0;
                    r_done_d = 1'b0;
                    if (per_slave_we_ni) begin
                        state_d = RD_REQ;
                    end else begin
                        state_d   = WR_REQ;
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                if (aw_hs) aw_pend_d = 1'b0;
                if (w_hs)  w_pend_d  = 1'b0;
                if ((!aw_pend_q || aw_hs) && (!w_pend_q || w_hs)) begin
                    state_d = atop_has_rdata(atop_q) ? ATOP_RESP : WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    opc_d   = (axi_b_resp_i != AXI_RESP_OKAY);
                    state_d = RESP;
                end
            end
            ATOP_RESP: begin
                if (b_hs) begin
                    b_done_d = 1'b1;
                    opc_d    = opc_d | (axi_b_resp_i != AXI_RESP_OKAY);
                end
                if (r_hs) begin
                    r_done_d = 1'b1;
                    rdata_d  = r_lane;
                    opc_d    = opc_d | axi_r_resp_i[1];
                end
                if ((b_done_q || b_hs) && (r_done_q || r_hs)) state_d = RESP;
            end
            RD_REQ: begin
                if (ar_hs) state_d = RD_RESP;
            end
            RD_RESP: begin
                if (r_hs) begin
                    rdata_d = r_lane;
                    opc_d   = axi_r_resp_i[1];
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            add_q     <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            atop_q    <= '0;
            id_q      <= '0;
            rdata_q   <= '0;
            opc_q     <= 1'b0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            b_done_q  <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            add_q     <= add_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            atop_q    <= atop_d;
            id_q      <= id_d;
            rdata_q   <= rdata_d;
            opc_q     <= opc_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            b_done_q  <= b_done_d;
            r_done_q  <= r_done_d;
        end
    end

endmodule

// File: tb/tb_per2axi_bridge.sv
// Self-checking bench for per2axi_bridge: directed scenarios plus randomized traffic against a latency/data model.
module tb_per2axi_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        per_slave_req_i;
    logic [31:0] per_slave_add_i;
    logic        per_slave_we_ni;
    logic [31:0] per_slave_wdata_i;
    logic [3:0]  per_slave_be_i;
    logic [5:0]  per_slave_atop_i;
    logic [4:0]  per_slave_id_i;
    logic        per_slave_gnt_o, per_slave_r_valid_o, per_slave_r_opc_o;
    logic [31:0] per_slave_r_rdata_o;
    logic [4:0]  per_slave_r_id_o;

    logic        axi_aw_valid_o, axi_aw_lock_o, axi_aw_ready_i;
    logic [31:0] axi_aw_addr_o;
    logic [2:0]  axi_aw_prot_o, axi_aw_size_o;
    logic [3:0]  axi_aw_region_o, axi_aw_cache_o, axi_aw_qos_o;
    logic [7:0]  axi_aw_len_o;
    logic [1:0]  axi_aw_burst_o;
    logic [5:0]  axi_aw_atop_o, axi_aw_id_o, axi_aw_user_o;
    logic        axi_w_valid_o, axi_w_last_o, axi_w_ready_i;
    logic [63:0] axi_w_data_o;
    logic [7:0]  axi_w_strb_o;
    logic [5:0]  axi_w_user_o;
    logic        axi_b_valid_i, axi_b_ready_o;
    logic [1:0]  axi_b_resp_i;
    logic [5:0]  axi_b_id_i, axi_b_user_i;
    logic        axi_ar_valid_o, axi_ar_lock_o, axi_ar_ready_i;
    logic [31:0] axi_ar_addr_o;
    logic [2:0]  axi_ar_prot_o, axi_ar_size_o;
    logic [3:0]  axi_ar_region_o, axi_ar_cache_o, axi_ar_qos_o;
    logic [7:0]  axi_ar_len_o;
    logic [1:0]  axi_ar_burst_o;
    logic [5:0]  axi_ar_id_o, axi_ar_user_o;
    logic        axi_r_valid_i, axi_r_last_i, axi_r_ready_o;
    logic [63:0] axi_r_data_i;
    logic [1:0]  axi_r_resp_i;
    logic [5:0]  axi_r_id_i, axi_r_user_i;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    per2axi_bridge dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .per_slave_req_i(per_slave_req_i), .per_slave_add_i(per_slave_add_i),
        .per_slave_we_ni(per_slave_we_ni), .per_slave_wdata_i(per_slave_wdata_i),
        .per_slave_be_i(per_slave_be_i), .per_slave_atop_i(per_slave_atop_i),
        .per_slave_id_i(per_slave_id_i), .per_slave_gnt_o(per_slave_gnt_o),
        .per_slave_r_valid_o(per_slave_r_valid_o), .per_slave_r_opc_o(per_slave_r_opc_o),
        .per_slave_r_rdata_o(per_slave_r_rdata_o), .per_slave_r_id_o(per_slave_r_id_o),
        .axi_aw_valid_o(axi_aw_valid_o), .axi_aw_addr_o(axi_aw_addr_o),
        .axi_aw_prot_o(axi_aw_prot_o), .axi_aw_region_o(axi_aw_region_o),
        .axi_aw_len_o(axi_aw_len_o), .axi_aw_size_o(axi_aw_size_o),
        .axi_aw_burst_o(axi_aw_burst_o), .axi_aw_lock_o(axi_aw_lock_o),
        .axi_aw_cache_o(axi_aw_cache_o), .axi_aw_qos_o(axi_aw_qos_o),
        .axi_aw_atop_o(axi_aw_atop_o), .axi_aw_id_o(axi_aw_id_o),
        .axi_aw_user_o(axi_aw_user_o), .axi_aw_ready_i(axi_aw_ready_i),
        .axi_w_valid_o(axi_w_valid_o), .axi_w_data_o(axi_w_data_o),
        .axi_w_strb_o(axi_w_strb_o), .axi_w_last_o(axi_w_last_o),
        .axi_w_user_o(axi_w_user_o), .axi_w_ready_i(axi_w_ready_i),
        .axi_b_valid_i(axi_b_valid_i), .axi_b_resp_i(axi_b_resp_i),
        .axi_b_id_i(axi_b_id_i), .axi_b_user_i(axi_b_user_i),
        .axi_b_ready_o(axi_b_ready_o),
        .axi_ar_valid_o(axi_ar_valid_o), .axi_ar_addr_o(axi_ar_addr_o),
        .axi_ar_prot_o(axi_ar_prot_o), .axi_ar_region_o(axi_ar_region_o),
        .axi_ar_len_o(axi_ar_len_o), .axi_ar_size_o(axi_ar_size_o),
        .axi_ar_burst_o(axi_ar_burst_o), .axi_ar_lock_o(axi_ar_lock_o),
        .axi_ar_cache_o(axi_ar_cache_o), .axi_ar_qos_o(axi_ar_qos_o),
        .axi_ar_id_o(axi_ar_id_o), .axi_ar_user_o(axi_ar_user_o),
        .axi_ar_ready_i(axi_ar_ready_i),
        .axi_r_valid_i(axi_r_valid_i), .axi_r_data_i(axi_r_data_i),
        .axi_r_resp_i(axi_r_resp_i), .axi_r_last_i(axi_r_last_i),
        .axi_r_id_i(axi_r_id_i), .axi_r_user_i(axi_r_user_i),
        .axi_r_ready_o(axi_r_ready_o),
        .busy_o(busy_o)
    );

    task automatic slave_idle();
        axi_aw_ready_i = 1'b0; axi_w_ready_i = 1'b0; axi_ar_ready_i = 1'b0;
        axi_b_valid_i  = 1'b0; axi_r_valid_i = 1'b0;
        axi_b_resp_i   = 2'b00; axi_r_resp_i = 2'b00; axi_r_data_i = '0;
        axi_b_id_i = '0; axi_b_user_i = '0; axi_r_id_i = '0; axi_r_user_i = '0;
        axi_r_last_i = 1'b1;
    endtask

    // One transaction: called and returns at a falling edge. Delays are slave stall cycles per channel;
    // B/R timers start the cycle after the request phase completes.
    task automatic run_txn(input logic [31:0] addr, input logic we_n, input logic [31:0] wdata,
                           input logic [3:0] be, input logic [5:0] atop, input logic [4:0] id,
                           input int aw_d, input int w_d, input int ar_d, input int b_d, input int r_d,
                           input logic [63:0] rd64, input logic [1:0] bresp, input logic [1:0] rresp);
        bit          is_wr = !we_n;
        bit          is_ld = !we_n && atop[5];
        logic [31:0] lane  = addr[2] ? rd64[63:32] : rd64[31:0];
        logic [7:0]  exp_strb = 8'({4'h0, be} << (addr[2] ? 4 : 0));
        logic [31:0] exp_rdata;
        logic        exp_opc;
        int          exp_lat, req_lat, t_aw, t_w, t_ar, t_b, t_r, t_both, c;

        req_lat = (aw_d > w_d) ? aw_d : w_d;
        if (!is_wr) begin
            exp_rdata = lane; exp_opc = rresp[1]; exp_lat = ar_d + r_d + 3;
        end else if (is_ld) begin
            exp_rdata = lane; exp_opc = (bresp != 2'b00) || rresp[1];
            exp_lat = req_lat + ((b_d > r_d) ? b_d : r_d) + 3;
        end else begin
            exp_rdata = 32'h0; exp_opc = (bresp != 2'b00); exp_lat = req_lat + b_d + 3;
        end

        per_slave_req_i = 1'b1; per_slave_add_i = addr; per_slave_we_ni = we_n;
        per_slave_wdata_i = wdata; per_slave_be_i = be; per_slave_atop_i = atop; per_slave_id_i = id;
        #1;
        n_checks++;
        if (per_slave_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL gnt: got %b required 1", per_slave_gnt_o);
        end
        @(negedge clk_i);
        per_slave_req_i = 1'b0;
        t_aw = -1; t_w = -1; t_ar = -1; t_b = -1; t_r = -1;
        c = 1;
        while (c <= exp_lat) begin
            t_both = (t_aw >= 0 && t_w >= 0) ? ((t_aw > t_w) ? t_aw : t_w) : -1;
            axi_aw_ready_i = is_wr && (c >= 1 + aw_d);
            axi_w_ready_i  = is_wr && (c >= 1 + w_d);
            axi_ar_ready_i = !is_wr && (c >= 1 + ar_d);
            axi_b_valid_i  = is_wr && t_both >= 0 && t_b < 0 && c >= t_both + 1 + b_d;
            axi_b_resp_i   = bresp;
            axi_r_valid_i  = t_r < 0 && ((!is_wr && t_ar >= 0 && c >= t_ar + 1 + r_d) ||
                                         (is_ld && t_both >= 0 && c >= t_both + 1 + r_d));
            axi_r_data_i   = rd64;
            axi_r_resp_i   = rresp;
            #1;
            n_checks++;
            if ({axi_aw_valid_o, axi_w_valid_o, axi_ar_valid_o} !== {is_wr && t_aw < 0, is_wr && t_w < 0, !is_wr && t_ar < 0}) begin
                n_fail++; $display("FAIL req_valids c=%0d: got aw/w/ar=%b%b%b required %b%b%b", c,
                    axi_aw_valid_o, axi_w_valid_o, axi_ar_valid_o, is_wr && t_aw < 0, is_wr && t_w < 0, !is_wr && t_ar < 0);
            end
            n_checks++;
            if ({axi_b_ready_o, axi_r_ready_o} !== {is_wr && t_both >= 0 && t_b < 0,
                    t_r < 0 && ((!is_wr && t_ar >= 0) || (is_ld && t_both >= 0))}) begin
                n_fail++; $display("FAIL resp_readys c=%0d: got b/r=%b%b", c, axi_b_ready_o, axi_r_ready_o);
            end
            n_checks++;
            if ({per_slave_r_valid_o, busy_o} !== {c == exp_lat, 1'b1}) begin
                n_fail++; $display("FAIL r_valid/busy c=%0d: got %b%b required %b1", c, per_slave_r_valid_o, busy_o, c == exp_lat);
            end
            if (axi_aw_valid_o) begin
                n_checks++;
                if ({axi_aw_addr_o, axi_aw_len_o, axi_aw_size_o, axi_aw_burst_o, axi_aw_atop_o, axi_aw_id_o,
                     axi_aw_lock_o, axi_aw_cache_o, axi_aw_prot_o, axi_aw_qos_o, axi_aw_region_o, axi_aw_user_o}
                    !== {addr, 8'd0, 3'd2, 2'b01, atop, 6'd0, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 6'd0}) begin
                    n_fail++; $display("FAIL aw_fields c=%0d: got addr=%h size=%0d atop=%h required addr=%h size=2 atop=%h",
                        c, axi_aw_addr_o, axi_aw_size_o, axi_aw_atop_o, addr, atop);
                end
            end
            if (axi_w_valid_o) begin
                n_checks++;
                if ({axi_w_data_o, axi_w_strb_o, axi_w_last_o, axi_w_user_o} !== {wdata, wdata, exp_strb, 1'b1, 6'd0}) begin
                    n_fail++; $display("FAIL w_fields c=%0d: got data=%h strb=%h last=%b required data=%h%h strb=%h last=1",
                        c, axi_w_data_o, axi_w_strb_o, axi_w_last_o, wdata, wdata, exp_strb);
                end
            end
            if (axi_ar_valid_o) begin
                n_checks++;
                if ({axi_ar_addr_o, axi_ar_len_o, axi_ar_size_o, axi_ar_burst_o, axi_ar_id_o, axi_ar_lock_o,
                     axi_ar_cache_o, axi_ar_prot_o, axi_ar_qos_o, axi_ar_region_o, axi_ar_user_o}
                    !== {addr, 8'd0, 3'd2, 2'b01, 6'd0, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 6'd0}) begin
                    n_fail++; $display("FAIL ar_fields c=%0d: got addr=%h size=%0d required addr=%h size=2",
                        c, axi_ar_addr_o, axi_ar_size_o, addr);
                end
            end
            if (per_slave_r_valid_o) begin
                n_checks++;
                if ({per_slave_r_rdata_o, per_slave_r_opc_o, per_slave_r_id_o} !== {exp_rdata, exp_opc, id}) begin
                    n_fail++; $display("FAIL response: got rdata=%h opc=%b id=%h required rdata=%h opc=%b id=%h",
                        per_slave_r_rdata_o, per_slave_r_opc_o, per_slave_r_id_o, exp_rdata, exp_opc, id);
                end
            end
            if (axi_aw_valid_o && axi_aw_ready_i) t_aw = c;
            if (axi_w_valid_o  && axi_w_ready_i)  t_w  = c;
            if (axi_ar_valid_o && axi_ar_ready_i) t_ar = c;
            if (axi_b_valid_i  && axi_b_ready_o)  t_b  = c;
            if (axi_r_valid_i  && axi_r_ready_o)  t_r  = c;
            @(negedge clk_i);
            c++;
        end
        slave_idle();
        n_checks++;
        if ({per_slave_r_valid_o, busy_o} !== 2'b00) begin
            n_fail++; $display("FAIL after_resp: got r_valid/busy=%b%b required 00", per_slave_r_valid_o, busy_o);
        end
        if (busy_o !== 1'b0) begin
            rst_i = 1'b1; @(negedge clk_i); rst_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        n_checks++;
        if ({per_slave_gnt_o, per_slave_r_valid_o, per_slave_r_opc_o, per_slave_r_rdata_o, per_slave_r_id_o,
             axi_aw_valid_o, axi_w_valid_o, axi_ar_valid_o, axi_b_ready_o, axi_r_ready_o, busy_o} !== '0) begin
            n_fail++; $display("FAIL reset_state: got gnt=%b rv=%b opc=%b rdata=%h id=%h aw/w/ar=%b%b%b b/r_rdy=%b%b busy=%b required all 0",
                per_slave_gnt_o, per_slave_r_valid_o, per_slave_r_opc_o, per_slave_r_rdata_o, per_slave_r_id_o,
                axi_aw_valid_o, axi_w_valid_o, axi_ar_valid_o, axi_b_ready_o, axi_r_ready_o, busy_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_read();
        run_txn(32'h1000_0004, 1'b1, 32'h0, 4'hF, 6'h0, 5'h15, 0, 0, 0, 0, 0,
                64'hAAAA_BBBB_1111_2222, 2'b00, 2'b00);
        run_txn(32'h1000_0000, 1'b1, 32'h0, 4'hF, 6'h0, 5'h03, 0, 0, 2, 0, 3,
                64'hAAAA_BBBB_1111_2222, 2'b00, 2'b10);
    endtask

    task automatic test_write_slverr();
        run_txn(32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 4'b0011, 6'h0, 5'h07, 0, 0, 0, 0, 0,
                64'h0, 2'b10, 2'b00);
    endtask

    task automatic test_write_stall();
        run_txn(32'h2000_0004, 1'b0, 32'h1234_5678, 4'b1100, 6'h0, 5'h0A, 5, 1, 0, 2, 0,
                64'h0, 2'b00, 2'b00);
    endtask

    task automatic test_atomic_swap();
        run_txn(32'h3000_0004, 1'b0, 32'hCAFE_F00D, 4'hF, 6'b110000, 5'h11, 0, 0, 0, 0, 2,
                64'h5555_6666_7777_8888, 2'b00, 2'b00);
        run_txn(32'h3000_0000, 1'b0, 32'h0BAD_F00D, 4'hF, 6'b110000, 5'h12, 1, 0, 0, 3, 0,
                64'h5555_6666_7777_8888, 2'b00, 2'b11);
        run_txn(32'h3000_0008, 1'b0, 32'h0000_0001, 4'hF, 6'b010001, 5'h13, 0, 2, 0, 1, 0,
                64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 2'b00);
    endtask

    task automatic test_read_atop();
        run_txn(32'h4000_0004, 1'b1, 32'h0, 4'hF, 6'b100000, 5'h1F, 0, 0, 1, 0, 1,
                64'h0102_0304_0506_0708, 2'b00, 2'b00);
    endtask

    task automatic test_reset_mid();
        per_slave_req_i = 1'b1; per_slave_add_i = 32'h5000_0000; per_slave_we_ni = 1'b1;
        per_slave_atop_i = 6'h0; per_slave_id_i = 5'h09;
        #1;
        n_checks++;
        if (per_slave_gnt_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_gnt: got %b required 1", per_slave_gnt_o); end
        @(negedge clk_i);
        per_slave_req_i = 1'b0;
        axi_ar_ready_i  = 1'b1;
        @(negedge clk_i);
        axi_ar_ready_i = 1'b0;
        n_checks++;
        if (axi_r_ready_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_rd_resp: got r_ready=%b required 1", axi_r_ready_o); end
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        n_checks++;
        if ({busy_o, axi_ar_valid_o, axi_r_ready_o, per_slave_r_valid_o} !== 4'b0000) begin
            n_fail++; $display("FAIL rstmid_idle: got busy/ar/r_rdy/rv=%b%b%b%b required 0000",
                busy_o, axi_ar_valid_o, axi_r_ready_o, per_slave_r_valid_o);
        end
        axi_r_valid_i = 1'b1; axi_r_data_i = 64'hDEAD_DEAD_DEAD_DEAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            n_checks++;
            if ({per_slave_r_valid_o, axi_r_ready_o} !== 2'b00) begin
                n_fail++; $display("FAIL rstmid_stale: got rv/r_rdy=%b%b required 00", per_slave_r_valid_o, axi_r_ready_o);
            end
        end
        slave_idle();
        run_txn(32'h5000_0004, 1'b1, 32'h0, 4'hF, 6'h0, 5'h0C, 0, 0, 0, 0, 0,
                64'h9999_8888_7777_6666, 2'b00, 2'b00);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            run_txn(32'h6000_0000 + 32'(i * 4), i[0], 32'h1111_0000 + 32'(i), 4'hF, 6'h0, 5'(i), 0, 0, 0, 0, 0,
                    64'hFEDC_BA98_7654_3210, 2'b00, 2'b00);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a    = $urandom & 32'hFFFF_FFFC;
            logic        we_n = 1'($urandom_range(0, 1));
            logic [5:0]  at   = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h0;
            run_txn(a, we_n, $urandom, 4'($urandom), at, 5'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    {$urandom, $urandom}, 2'($urandom), 2'($urandom));
        end
    endtask

    initial begin
        per_slave_req_i = 1'b0; per_slave_add_i = '0; per_slave_we_ni = 1'b1;
        per_slave_wdata_i = '0; per_slave_be_i = '0; per_slave_atop_i = '0; per_slave_id_i = '0;
        slave_idle();
        @(negedge clk_i);
        test_reset();
        test_read();
        test_write_slverr();
        test_write_stall();
        test_atomic_swap();
        test_read_atop();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
